// File: rtl/taus_pkg.sv
// Shared constants, FSM state type and the single-component step function
// for the three-component Tausworthe stream checker.
package taus_pkg;

    localparam logic [31:0] SEED0_DEF = 32'hffffffff;
    localparam logic [31:0] SEED1_DEF = 32'hcccccccc;
    localparam logic [31:0] SEED2_DEF = 32'h00ff00ff;

    // Shift constants per component: left-feedback, right, left-update.
    localparam int unsigned C0_SL = 13;
    localparam int unsigned C0_SR = 19;
    localparam int unsigned C0_SM = 12;
    localparam int unsigned C1_SL = 2;
    localparam int unsigned C1_SR = 25;
    localparam int unsigned C1_SM = 4;
    localparam int unsigned C2_SL = 3;
    localparam int unsigned C2_SR = 11;
    localparam int unsigned C2_SM = 17;

    localparam logic [31:0] C0_MASK = 32'hfffffffe;
    localparam logic [31:0] C1_MASK = 32'hfffffff8;
    localparam logic [31:0] C2_MASK = 32'hfffffff0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAIL    = 2'd3
    } chk_state_e;

    // One step of a single Tausworthe component (logical shifts only).
    function automatic logic [31:0] taus_step(
        input logic [31:0] s,
        input logic [31:0] mask,
        input int unsigned sl,
        input int unsigned sr,
        input int unsigned sm
    );
        logic [31:0] b;
        b = ((s << sl) ^ s) >> sr;
        return ((s & mask) << sm) ^ b;
    endfunction

endpackage

// File: rtl/taus_model.sv
// Local copy of the generator recurrence. Holds the three component
// registers, reloads the seeds on reset or clear, and steps on advance_i.
module taus_model
    import taus_pkg::*;
#(
    parameter logic [31:0] S0 = SEED0_DEF,
    parameter logic [31:0] S1 = SEED1_DEF,
    parameter logic [31:0] S2 = SEED2_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        advance_i,
    output logic [31:0] expected_o
);

    logic [31:0] m0_q, m1_q, m2_q;
    logic [31:0] m0_d, m1_d, m2_d;

    // Next model state: clear reloads seeds and overrides an advance.
    always_comb begin
        m0_d = m0_q;
        m1_d = m1_q;
        m2_d = m2_q;
        if (clear_i) begin
            m0_d = S0;
            m1_d = S1;
            m2_d = S2;
        end else if (advance_i) begin
            m0_d = taus_step(m0_q, C0_MASK, C0_SL, C0_SR, C0_SM);
            m1_d = taus_step(m1_q, C1_MASK, C1_SL, C1_SR, C1_SM);
            m2_d = taus_step(m2_q, C2_MASK, C2_SL, C2_SR, C2_SM);
        end
    end

    // Component registers, seeded on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m0_q <= S0;
            m1_q <= S1;
            m2_q <= S2;
        end else begin
            m0_q <= m0_d;
            m1_q <= m1_d;
            m2_q <= m2_d;
        end
    end

    assign expected_o = m0_q ^ m1_q ^ m2_q;

endmodule

// File: rtl/taus_checker.sv
// Sink-side checker for a Tausworthe word stream: compares every accepted
// word against the local model, tracks lock/fail and saturating counters.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no word seen since reset/clear
// ST_ACQUIRE | counting consecutive matches towards LOCK_COUNT
// ST_LOCKED  | stream in sync; mismatches counted but lock held
// ST_FAIL    | error limit reached; sticky until reset/clear
module taus_checker
    import taus_pkg::*;
#(
    parameter logic [31:0] S0         = SEED0_DEF,
    parameter logic [31:0] S1         = SEED1_DEF,
    parameter logic [31:0] S2         = SEED2_DEF,
    parameter int          LOCK_COUNT = 4,
    parameter int          ERR_LIMIT  = 8,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      data_in,
    input  logic             valid_in,
    input  logic             clear,
    output logic             locked,
    output logic             fail,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    chk_state_e       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_next;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             mm_q, mm_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;

    logic             accept;
    logic             word_miss;
    logic             err_hit;
    logic [31:0]      expected;

    // clear beats a simultaneous valid word: the word is dropped entirely.
    assign accept    = valid_in & ~clear;
    assign word_miss = accept & (data_in != expected);

    taus_model #(
        .S0 (S0),
        .S1 (S1),
        .S2 (S2)
    ) u_model (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clear_i    (clear),
        .advance_i  (accept),
        .expected_o (expected)
    );

    // Next-state, counters and output flags for the checker FSM.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        err_d    = err_q;
        words_d  = words_q;
        mm_d     = 1'b0;
        run_next = word_miss ? '0 : ((run_q == RUN_TGT) ? run_q : run_q + 1'b1);
        err_hit  = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            run_d   = '0;
            err_d   = '0;
            words_d = '0;
        end else if (accept) begin
            mm_d    = word_miss;
            words_d = (words_q == CNT_MAX) ? words_q : words_q + 1'b1;
            if (word_miss) begin
                err_d = (err_q == CNT_MAX) ? err_q : err_q + 1'b1;
            end
            err_hit = (32'(err_d) >= 32'(ERR_LIMIT));

            unique case (state_q)
                // The first word after IDLE already counts towards the run.
                ST_IDLE, ST_ACQUIRE: begin
                    run_d = run_next;
                    if (err_hit) begin
                        state_d = ST_FAIL;
                    end else if (run_next == RUN_TGT) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_ACQUIRE;
                    end
                end
                ST_LOCKED: begin
                    if (err_hit) begin
                        state_d = ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
        fail_d   = (state_d == ST_FAIL);
    end

    // Checker state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            run_q    <= '0;
            err_q    <= '0;
            words_q  <= '0;
            mm_q     <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            err_q    <= err_d;
            words_q  <= words_d;
            mm_q     <= mm_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
        end
    end

    assign locked     = locked_q;
    assign fail       = fail_q;
    assign mismatch   = mm_q;
    assign err_count  = err_q;
    assign word_count = words_q;

endmodule

// File: tb/tb_taus_checker.sv
// Bench for taus_checker: a bench-side generator feeds the stream, a reference
// checker model pushes expected outputs per driven cycle, and a monitor pops
// and compares one cycle later. A second instance with 4-bit counters covers
// counter saturation.
module tb_taus_checker;

    localparam int LOCK_COUNT = 4;
    localparam int ERR_LIMIT  = 8;

    logic        clk;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        clear;
    logic        locked, fail, mismatch;
    logic [15:0] err_count, word_count;
    logic        s_locked, s_fail, s_mismatch;
    logic [3:0]  s_err, s_words;

    int checks = 0;
    int errors = 0;

    taus_checker dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .clear      (clear),
        .locked     (locked),
        .fail       (fail),
        .mismatch   (mismatch),
        .err_count  (err_count),
        .word_count (word_count)
    );

    taus_checker #(.CNT_W(4)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .clear      (clear),
        .locked     (s_locked),
        .fail       (s_fail),
        .mismatch   (s_mismatch),
        .err_count  (s_err),
        .word_count (s_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator recurrence, written out with literal constants.
    function automatic logic [31:0] step0(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 13) ^ s) >> 19;
        return ((s & 32'hfffffffe) << 12) ^ b;
    endfunction
    function automatic logic [31:0] step1(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 2) ^ s) >> 25;
        return ((s & 32'hfffffff8) << 4) ^ b;
    endfunction
    function automatic logic [31:0] step2(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 3) ^ s) >> 11;
        return ((s & 32'hfffffff0) << 17) ^ b;
    endfunction

    logic [31:0] g0, g1, g2;   // generator feeding the stream
    logic [31:0] r0, r1, r2;   // reference checker model
    int r_state, r_run, r_err, r_words;   // 0 idle, 1 acquire, 2 locked, 3 fail

    typedef struct {
        logic mm;
        logic lk;
        logic fl;
        int   err;
        int   words;
    } exp_t;
    exp_t sb[$];

    task automatic gen_seed();
        g0 = 32'hffffffff; g1 = 32'hcccccccc; g2 = 32'h00ff00ff;
    endtask

    task automatic gen_next();
        g0 = step0(g0); g1 = step1(g1); g2 = step2(g2);
    endtask

    task automatic ref_reset();
        r0 = 32'hffffffff; r1 = 32'hcccccccc; r2 = 32'h00ff00ff;
        r_state = 0; r_run = 0; r_err = 0; r_words = 0;
    endtask

    // Drive one cycle of inputs and push what the outputs must be after it.
    task automatic drive(input logic v, input logic [31:0] d, input logic c);
        exp_t e;
        logic m;
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        clear    = c;
        m = 1'b0;
        if (c) begin
            ref_reset();
        end else if (v) begin
            m = (d !== (r0 ^ r1 ^ r2));
            r0 = step0(r0); r1 = step1(r1); r2 = step2(r2);
            r_words++;
            if (m) r_err++;
            if (r_state == 0) r_state = 1;
            if (r_state == 1) begin
                r_run = m ? 0 : r_run + 1;
                if (r_err >= ERR_LIMIT) r_state = 3;
                else if (r_run >= LOCK_COUNT) r_state = 2;
            end else if (r_state == 2 && r_err >= ERR_LIMIT) begin
                r_state = 3;
            end
        end
        e.mm = m;
        e.lk = (r_state == 2);
        e.fl = (r_state == 3);
        e.err = r_err;
        e.words = r_words;
        sb.push_back(e);
    endtask

    task automatic send_good();
        drive(1'b1, g0 ^ g1 ^ g2, 1'b0);
        gen_next();
    endtask

    task automatic send_bad(input logic [31:0] flip);
        drive(1'b1, (g0 ^ g1 ^ g2) ^ flip, 1'b0);
        gen_next();
    endtask

    task automatic send_idle();
        drive(1'b0, $urandom, 1'b0);
    endtask

    task automatic settle();
        send_idle();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: outputs after each edge against the pushed expectation.
    always @(posedge clk) begin : monitor
        exp_t e;
        int   sat_err, sat_words;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            sat_err   = (e.err > 15) ? 15 : e.err;
            sat_words = (e.words > 15) ? 15 : e.words;
            checks += 7;
            if (mismatch !== e.mm) begin
                errors++;
                $display("FAIL sb_mismatch: got %0b expected %0b at %0t", mismatch, e.mm, $time);
            end
            if (locked !== e.lk) begin
                errors++;
                $display("FAIL sb_locked: got %0b expected %0b at %0t", locked, e.lk, $time);
            end
            if (fail !== e.fl) begin
                errors++;
                $display("FAIL sb_fail: got %0b expected %0b at %0t", fail, e.fl, $time);
            end
            if (err_count !== 16'(e.err)) begin
                errors++;
                $display("FAIL sb_err_count: got %0d expected %0d at %0t", err_count, e.err, $time);
            end
            if (word_count !== 16'(e.words)) begin
                errors++;
                $display("FAIL sb_word_count: got %0d expected %0d at %0t", word_count, e.words, $time);
            end
            if (s_err !== 4'(sat_err)) begin
                errors++;
                $display("FAIL sb_sat_err: got %0d expected %0d at %0t", s_err, sat_err, $time);
            end
            if (s_words !== 4'(sat_words)) begin
                errors++;
                $display("FAIL sb_sat_words: got %0d expected %0d at %0t", s_words, sat_words, $time);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0; valid_in = 1'b0; clear = 1'b0; data_in = '0;
        gen_seed(); ref_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({locked, fail, mismatch, err_count, word_count} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got l=%0b f=%0b m=%0b e=%0d w=%0d expected all 0",
                     locked, fail, mismatch, err_count, word_count);
        end
        reset = 1'b1;
    endtask

    task automatic test_stream();
        repeat (1000) send_good();
        settle();
        checks++;
        if (locked !== 1'b1 || err_count !== 16'd0 || word_count !== 16'd1000) begin
            errors++;
            $display("FAIL stream_1000: got l=%0b e=%0d w=%0d expected l=1 e=0 w=1000",
                     locked, err_count, word_count);
        end
        checks++;
        if (s_words !== 4'd15) begin
            errors++;
            $display("FAIL word_saturate: got %0d expected 15", s_words);
        end
    endtask

    task automatic test_bit_flip();
        send_bad(32'h1);
        @(posedge clk); #2;
        checks++;
        if (mismatch !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL bit_flip_pulse: got m=%0b e=%0d l=%0b expected m=1 e=1 l=1",
                     mismatch, err_count, locked);
        end
        send_good();
        @(posedge clk); #2;
        checks++;
        if (mismatch !== 1'b0) begin
            errors++;
            $display("FAIL bit_flip_one_pulse: got %0b expected 0", mismatch);
        end
        repeat (20) send_good();
        settle();
        checks++;
        if (err_count !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL bit_flip_resync: got e=%0d l=%0b expected e=1 l=1", err_count, locked);
        end
    endtask

    task automatic test_fail();
        drive(1'b0, 32'h0, 1'b1);
        gen_seed();
        repeat (4) send_good();
        for (int i = 0; i < 8; i++) send_bad(32'h1 << (i * 3));
        @(posedge clk); #2;
        checks++;
        if (fail !== 1'b1 || locked !== 1'b0 || err_count !== 16'd8) begin
            errors++;
            $display("FAIL fail_entry: got f=%0b l=%0b e=%0d expected f=1 l=0 e=8",
                     fail, locked, err_count);
        end
        for (int i = 0; i < 10; i++) send_bad(32'h8000_0000 >> i);
        repeat (20) send_good();
        settle();
        checks++;
        if (fail !== 1'b1 || err_count !== 16'd18 || word_count !== 16'd42) begin
            errors++;
            $display("FAIL fail_sticky: got f=%0b e=%0d w=%0d expected f=1 e=18 w=42",
                     fail, err_count, word_count);
        end
        checks++;
        if (s_err !== 4'd15) begin
            errors++;
            $display("FAIL err_saturate: got %0d expected 15", s_err);
        end
    endtask

    task automatic test_gaps();
        drive(1'b0, 32'h0, 1'b1);
        gen_seed();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) send_idle();
            send_good();
        end
        settle();
        checks++;
        if (locked !== 1'b1 || err_count !== 16'd0 || word_count !== 16'd40) begin
            errors++;
            $display("FAIL gaps: got l=%0b e=%0d w=%0d expected l=1 e=0 w=40",
                     locked, err_count, word_count);
        end
    endtask

    task automatic test_acquire_run();
        drive(1'b0, 32'h0, 1'b1);
        gen_seed();
        repeat (3) send_good();
        send_bad(32'h10);
        settle();
        checks++;
        if (locked !== 1'b0 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL acquire_break: got l=%0b e=%0d expected l=0 e=1", locked, err_count);
        end
        repeat (3) send_good();
        settle();
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL acquire_three_more: got %0b expected 0", locked);
        end
        send_good();
        @(posedge clk); #2;
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL acquire_relock: got %0b expected 1", locked);
        end
    endtask

    task automatic test_clear_with_valid();
        drive(1'b1, g0 ^ g1 ^ g2, 1'b1);
        gen_seed();
        @(posedge clk); #2;
        checks++;
        if ({locked, fail, mismatch, err_count, word_count} !== 35'd0) begin
            errors++;
            $display("FAIL clear_outputs: got l=%0b f=%0b m=%0b e=%0d w=%0d expected all 0",
                     locked, fail, mismatch, err_count, word_count);
        end
        drive(1'b1, 32'h33cc33cc, 1'b0);
        gen_next();
        @(posedge clk); #2;
        checks++;
        if (mismatch !== 1'b0 || word_count !== 16'd1 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_first_word: got m=%0b w=%0d e=%0d expected m=0 w=1 e=0",
                     mismatch, word_count, err_count);
        end
    endtask

    task automatic test_mid_reset();
        repeat (10) send_good();
        send_bad(32'h4);
        @(negedge clk);
        valid_in = 1'b0;
        reset = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({locked, fail, mismatch, err_count, word_count} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got l=%0b f=%0b m=%0b e=%0d w=%0d expected all 0",
                     locked, fail, mismatch, err_count, word_count);
        end
        ref_reset();
        gen_seed();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 32'h33cc33cc, 1'b0);
        gen_next();
        repeat (5) send_good();
        settle();
        checks++;
        if (locked !== 1'b1 || word_count !== 16'd6 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_restart: got l=%0b w=%0d e=%0d expected l=1 w=6 e=0",
                     locked, word_count, err_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_bit_flip();
        test_fail();
        test_gaps();
        test_acquire_run();
        test_clear_with_valid();
        test_mid_reset();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
